// File: rtl/dot_product_master_if.sv
// Single-beat byte memory channel set between the dot-product initiator and its responder.
interface dot_product_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wvalid;
  logic                  wready;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wvalid, input wready,
    input bvalid, output bready,
    output araddr, arvalid, input arready,
    input rdata, rvalid, output rready
  );

  modport slave (
    input awaddr, awvalid, output awready,
    input wdata, wvalid, output wready,
    output bvalid, input bready,
    input araddr, arvalid, output arready,
    output rdata, rvalid, input rready
  );
endinterface

// File: rtl/dot_product_master.sv
// Reads two byte vectors, multiply-accumulates them, and writes the result back LSB first.
// Define DOT_SIGNED_EN to treat the operand bytes as two's-complement (default: unsigned).
module dot_product_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned ACC_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  input  logic [ADDR_WIDTH-1:0] base_r,
  output logic                  busy,
  output logic                  done,
  output logic [ACC_WIDTH-1:0]  result,
  dot_product_master_if.master  mem
);
  localparam int unsigned NBYTES = ACC_WIDTH / 8;
  localparam int unsigned KW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned PW     = 2 * DATA_WIDTH;
  localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

  typedef enum logic [3:0] {
    IDLE, RA_ADDR, RA_DATA, RB_ADDR, RB_DATA, MAC, W_ADDR, W_DATA, W_RESP, FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d, index_q, index_d;
  logic [ADDR_WIDTH-1:0] ba_q, ba_d, bb_q, bb_d, br_q, br_d;
  logic [KW-1:0]         k_q, k_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d, result_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d, awaddr_q, awaddr_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic busy_d, done_d;
  logic [PW-1:0]         prod;
  logic [ACC_WIDTH-1:0]  prod_ext;

  // Product extension into the accumulator width depends on operand signedness
`ifdef DOT_SIGNED_EN
  assign prod     = {{DATA_WIDTH{a_q[DATA_WIDTH-1]}}, a_q} * {{DATA_WIDTH{b_q[DATA_WIDTH-1]}}, b_q};
  assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
`else
  assign prod     = PW'(a_q) * PW'(b_q);
  assign prod_ext = ACC_WIDTH'(prod);
`endif

  assign mem.araddr  = araddr_q;
  assign mem.arvalid = arvalid_q;
  assign mem.rready  = rready_q;
  assign mem.awaddr  = awaddr_q;
  assign mem.awvalid = awvalid_q;
  assign mem.wdata   = wdata_q;
  assign mem.wvalid  = wvalid_q;
  assign mem.bready  = bready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      index_q   <= '0;
      ba_q      <= '0;
      bb_q      <= '0;
      br_q      <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awaddr_q  <= '0;
      awvalid_q <= 1'b0;
      wdata_q   <= '0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      index_q   <= index_d;
      ba_q      <= ba_d;
      bb_q      <= bb_d;
      br_q      <= br_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awaddr_q  <= awaddr_d;
      awvalid_q <= awvalid_d;
      wdata_q   <= wdata_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      busy      <= busy_d;
      done      <= done_d;
      result    <= result_d;
    end
  end

  // Next-state and next-output logic; every channel control is registered
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    index_d   = index_q;
    ba_d      = ba_q;
    bb_d      = bb_q;
    br_d      = br_q;
    k_d       = k_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awaddr_d  = awaddr_q;
    awvalid_d = awvalid_q;
    wdata_d   = wdata_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    busy_d    = busy;
    done_d    = 1'b0;
    result_d  = result;

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len;
          ba_d    = base_a;
          bb_d    = base_b;
          br_d    = base_r;
          acc_d   = '0;
          index_d = '0;
          k_d     = '0;
          busy_d  = 1'b1;
          if (len == '0) begin
            state_d   = W_ADDR;
            awvalid_d = 1'b1;
            awaddr_d  = base_r;
          end else begin
            state_d   = RA_ADDR;
            arvalid_d = 1'b1;
            araddr_d  = base_a;
          end
        end
      end
      RA_ADDR, RB_ADDR: begin
        if (arvalid_q && mem.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = (state_q == RA_ADDR) ? RA_DATA : RB_DATA;
        end
      end
      RA_DATA: begin
        if (mem.rvalid && rready_q) begin
          a_d       = mem.rdata;
          rready_d  = 1'b0;
          arvalid_d = 1'b1;
          araddr_d  = bb_q + ADDR_WIDTH'(index_q);
          state_d   = RB_ADDR;
        end
      end
      RB_DATA: begin
        if (mem.rvalid && rready_q) begin
          b_d      = mem.rdata;
          rready_d = 1'b0;
          state_d  = MAC;
        end
      end
      MAC: begin
        acc_d   = acc_q + prod_ext;
        index_d = index_q + LEN_WIDTH'(1);
        if (index_d == len_q) begin
          state_d   = W_ADDR;
          k_d       = '0;
          awvalid_d = 1'b1;
          awaddr_d  = br_q;
        end else begin
          state_d   = RA_ADDR;
          arvalid_d = 1'b1;
          araddr_d  = ba_q + ADDR_WIDTH'(index_d);
        end
      end
      W_ADDR: begin
        if (awvalid_q && mem.awready) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          wdata_d   = DATA_WIDTH'(acc_q >> {k_q, 3'b000});
          state_d   = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid_q && mem.wready) begin
          wvalid_d = 1'b0;
          bready_d = 1'b1;
          state_d  = W_RESP;
        end
      end
      W_RESP: begin
        if (mem.bvalid && bready_q) begin
          bready_d = 1'b0;
          if (k_q == K_LAST) begin
            state_d  = FINISH;
            result_d = acc_q;
            done_d   = 1'b1;
            busy_d   = 1'b0;
          end else begin
            k_d       = k_q + KW'(1);
            awvalid_d = 1'b1;
            awaddr_d  = br_q + ADDR_WIDTH'(k_d);
            state_d   = W_ADDR;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dot_product_master.sv
// Directed bench for dot_product_master with a byte-memory responder and queue scoreboard.
`timescale 1ns/1ps
module tb_dot_product_master;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic [31:0] base_a = '0, base_b = '0, base_r = '0;
  logic        busy, done;
  logic [23:0] result;

  int checks = 0, errors = 0;
  int stall = 0;
  int rd_total = 0, wr_total = 0, done_cnt = 0;

  logic [7:0]  rmem [0:1023];
  logic [7:0]  wmem [0:1023];
  logic [31:0] exp_ar [$];
  logic [39:0] exp_w  [$];
  logic [23:0] exp_res [$];

  logic        r_pend, w_pend;
  int          r_cnt, b_cnt;
  logic [31:0] ar_lat, aw_lat;
  logic [7:0]  w_lat;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  always #5 clk = ~clk;

  dot_product_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(8)) mem_if ();

  dot_product_master dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .base_a(base_a), .base_b(base_b), .base_r(base_r),
    .busy(busy), .done(done), .result(result), .mem(mem_if)
  );

  assign mem_if.arready = 1'b1;
  assign mem_if.awready = 1'b1;
  assign mem_if.wready  = 1'b1;

  // Responder: answers each read/write after 'stall' idle cycles
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_if.rvalid <= 1'b0;
      mem_if.rdata  <= '0;
      mem_if.bvalid <= 1'b0;
      r_pend <= 1'b0; w_pend <= 1'b0;
      r_cnt <= 0; b_cnt <= 0;
      ar_lat <= '0; aw_lat <= '0; w_lat <= '0;
    end else begin
      if (mem_if.arvalid && mem_if.arready) begin
        ar_lat <= mem_if.araddr; r_pend <= 1'b1; r_cnt <= stall;
      end
      if (r_pend && !mem_if.rvalid) begin
        if (r_cnt == 0) begin
          mem_if.rvalid <= 1'b1; mem_if.rdata <= rmem[ar_lat[9:0]];
        end else r_cnt <= r_cnt - 1;
      end
      if (mem_if.rvalid && mem_if.rready) begin
        mem_if.rvalid <= 1'b0; r_pend <= 1'b0;
      end
      if (mem_if.awvalid && mem_if.awready) aw_lat <= mem_if.awaddr;
      if (mem_if.wvalid && mem_if.wready) begin
        w_lat <= mem_if.wdata; w_pend <= 1'b1; b_cnt <= stall;
      end
      if (w_pend && !mem_if.bvalid) begin
        if (b_cnt == 0) mem_if.bvalid <= 1'b1;
        else b_cnt <= b_cnt - 1;
      end
      if (mem_if.bvalid && mem_if.bready) begin
        mem_if.bvalid <= 1'b0; w_pend <= 1'b0; wmem[aw_lat[9:0]] <= w_lat;
      end
    end
  end

  // Scoreboard and hold monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_if.arvalid && mem_if.arready) begin
        rd_total++;
        chk("read_expected", exp_ar.size() != 0, 1'b1);
        if (exp_ar.size() != 0) chk("read_order", mem_if.araddr, exp_ar.pop_front());
      end
      if (mem_if.bvalid && mem_if.bready) begin
        wr_total++;
        chk("write_expected", exp_w.size() != 0, 1'b1);
        if (exp_w.size() != 0) chk("write_addr_data", {aw_lat, w_lat}, exp_w.pop_front());
      end
      if (r_pend) chk("araddr_hold", mem_if.araddr, ar_lat);
      if (w_pend) begin
        chk("awaddr_hold", mem_if.awaddr, aw_lat);
        chk("wdata_hold", mem_if.wdata, w_lat);
      end
      if (done) begin
        done_cnt++;
        chk("done_expected", exp_res.size() != 0, 1'b1);
        if (exp_res.size() != 0) chk("result_sb", result, exp_res.pop_front());
      end
    end
  end

  function automatic logic [23:0] model(input int n, input int ba, input int bb);
    logic [23:0] s = '0;
    int p, q;
    for (int i = 0; i < n; i++) begin
`ifdef DOT_SIGNED_EN
      p = $signed(rmem[(ba + i) % 1024]);
      q = $signed(rmem[(bb + i) % 1024]);
`else
      p = int'(rmem[(ba + i) % 1024]);
      q = int'(rmem[(bb + i) % 1024]);
`endif
      s = s + 24'(p * q);
    end
    return s;
  endfunction

  task automatic launch(input int n, input logic [31:0] ba, input logic [31:0] bb,
                        input logic [31:0] br);
    logic [23:0] e;
    e = model(n, int'(ba), int'(bb));
    for (int i = 0; i < n; i++) begin
      exp_ar.push_back(ba + 32'(i));
      exp_ar.push_back(bb + 32'(i));
    end
    for (int k = 0; k < 3; k++) exp_w.push_back({br + 32'(k), e[8*k +: 8]});
    exp_res.push_back(e);
    @(negedge clk);
    start = 1'b1; len = 16'(n); base_a = ba; base_b = bb; base_r = br;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    bit seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk); #1;
      seen = (done_cnt > d0);
    end
    chk("done_within_budget", seen, 1'b1);
    chk("busy_after_done", busy, 1'b0);
  endtask

  task automatic load_vec(input int n, input logic [7:0] a0, input logic [7:0] a1,
                          input logic [7:0] a2, input logic [7:0] a3,
                          input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    rmem[0] = a0; rmem[1] = a1; rmem[2] = a2; rmem[3] = a3;
    rmem[256] = b0; rmem[257] = b1; rmem[258] = b2; rmem[259] = b3;
    if (n < 4) begin rmem[n] = 8'h00; rmem[256 + n] = 8'h00; end
  endtask

  initial begin
    int r0, w0, d0;
    bit hit;
    for (int i = 0; i < 1024; i++) begin rmem[i] = 8'h00; wmem[i] = 8'h00; end
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 24'h0);
    chk("rst_valids", {mem_if.arvalid, mem_if.rready, mem_if.awvalid, mem_if.wvalid, mem_if.bready}, 5'b0);
    chk("rst_addrs", {mem_if.araddr, mem_if.awaddr, mem_if.wdata}, 72'h0);
    rst_n = 1'b1;

    // 1: basic dot product
    load_vec(3, 8'd1, 8'd2, 8'd3, 8'd0, 8'd4, 8'd5, 8'd6, 8'd0);
    r0 = rd_total; w0 = wr_total; d0 = done_cnt;
    launch(3, 32'd0, 32'd256, 32'd512);
    wait_done(500);
    chk("t1_result", result, 24'h000020);
    chk("t1_mem", {wmem[512], wmem[513], wmem[514]}, 24'h200000);
    chk("t1_reads", rd_total - r0, 6);
    chk("t1_writes", wr_total - w0, 3);
    chk("t1_done_pulses", done_cnt - d0, 1);

    // 4: start while busy is ignored
    d0 = done_cnt;
    launch(3, 32'd0, 32'd256, 32'd512);
    repeat (5) @(negedge clk);
    start = 1'b1; len = 16'd4; base_a = 32'd100;
    @(negedge clk);
    start = 1'b0;
    wait_done(500);
    repeat (20) @(negedge clk);
    chk("t4_done_pulses", done_cnt - d0, 1);
    chk("t4_result", result, 24'h000020);

    // 2: zero length
    r0 = rd_total; w0 = wr_total;
    for (int i = 600; i < 603; i++) wmem[i] = 8'hAA;
    launch(0, 32'd0, 32'd256, 32'd600);
    wait_done(500);
    chk("t2_result", result, 24'h0);
    chk("t2_reads", rd_total - r0, 0);
    chk("t2_writes", wr_total - w0, 3);
    chk("t2_mem", {wmem[600], wmem[601], wmem[602]}, 24'h0);

    // 5: reset during RB_DATA, then clean rerun
    r0 = rd_total;
    launch(3, 32'd0, 32'd256, 32'd512);
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      hit = (rd_total - r0 >= 2) && mem_if.rready;
    end
    chk("t5_reached_rb_data", hit, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_valids", {mem_if.arvalid, mem_if.rready, mem_if.awvalid, mem_if.wvalid, mem_if.bready}, 5'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_done", done, 1'b0);
    exp_ar.delete(); exp_w.delete(); exp_res.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    launch(3, 32'd0, 32'd256, 32'd512);
    wait_done(500);
    chk("t5_result", result, 24'h000020);

    // 3: all ones, zero-wait then stalled responder
    load_vec(4, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    launch(4, 32'd0, 32'd256, 32'd512);
    wait_done(500);
`ifdef DOT_SIGNED_EN
    chk("t3_result", result, 24'h000004);
`else
    chk("t3_result", result, 24'h03F804);
`endif
    stall = 5;
    launch(4, 32'd0, 32'd256, 32'd700);
    wait_done(2000);
`ifdef DOT_SIGNED_EN
    chk("t3_stall_result", result, 24'h000004);
`else
    chk("t3_stall_result", result, 24'h03F804);
    chk("t3_stall_mem", {wmem[700], wmem[701], wmem[702]}, 24'h04F803);
`endif
    stall = 0;

    // 6: operand signedness
    load_vec(1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00);
    launch(1, 32'd0, 32'd256, 32'd512);
    wait_done(500);
`ifdef DOT_SIGNED_EN
    chk("t6_result", result, 24'hFFFFFE);
`else
    chk("t6_result", result, 24'h0001FE);
`endif

    repeat (5) @(negedge clk);
    chk("sb_reads_drained", exp_ar.size(), 0);
    chk("sb_writes_drained", exp_w.size(), 0);
    chk("sb_results_drained", exp_res.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
